// File: rtl/frame_tick_scheduler.sv
// frame_tick_scheduler: divides clk down to a frame tick and
// drives NUM_CH independent every-N-frames go strobes.
module frame_tick_scheduler #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned REFRESH_HZ = 60,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PER_W      = 4,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH*PER_W-1:0] period,
  input  logic [NUM_CH-1:0]       restart,
  output logic                    refresh,
  output logic [NUM_CH-1:0]       go,
  output logic [FCNT_W-1:0]       frame_count
);

  localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("frame_tick_scheduler: CLK_HZ/REFRESH_HZ must be >= 2");
    end
  endgenerate

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = enable && (div_cnt == '0);

  // Frame divider: counts down while enabled, reloads on tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= DIV_LAST;
      refresh <= 1'b0;
    end else begin
      refresh <= tick;
      if (tick)
        div_cnt <= DIV_LAST;
      else if (enable)
        div_cnt <= div_cnt - DW'(1);
    end
  end

  // Free-running frame counter, wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_count <= '0;
    else if (tick)
      frame_count <= frame_count + FCNT_W'(1);
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [PER_W-1:0] per;
      logic [PER_W-1:0] reload;
      logic [PER_W-1:0] ch_cnt;

      assign per    = period[i*PER_W +: PER_W];
      assign reload = (per == '0) ? '0 : per - PER_W'(1);

      // Channel countdown: fires on count zero, restart forces resync.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ch_cnt <= '0;
          go[i]  <= 1'b0;
        end else if (restart[i]) begin
          ch_cnt <= '0;
          go[i]  <= 1'b0;
        end else if (tick && ch_cnt == '0) begin
          ch_cnt <= reload;
          go[i]  <= 1'b1;
        end else if (tick) begin
          ch_cnt <= ch_cnt - PER_W'(1);
          go[i]  <= 1'b0;
        end else begin
          go[i]  <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// tb_frame_tick_scheduler: directed checks with DIV=10,
// four channels, 4-bit periods and a 4-bit frame counter.
module tb_frame_tick_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic [3:0]  restart;
  logic        refresh;
  logic [3:0]  go;
  logic [3:0]  frame_count;

  int checks;
  int passes;

  frame_tick_scheduler #(
    .CLK_HZ(100),
    .REFRESH_HZ(10),
    .NUM_CH(4),
    .PER_W(4),
    .FCNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .period(period),
    .restart(restart),
    .refresh(refresh),
    .go(go),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: nine quiet edges, then the refresh edge.
  // rmask is driven as restart during the tick cycle.
  task automatic frame(input int k,
                       input logic [3:0] exp_go,
                       input logic [3:0] rmask);
    step(9);
    check($sformatf("quiet_%0d", k), {31'd0, refresh}, 32'd0);
    restart = rmask;
    step(1);
    restart = 4'b0000;
    check($sformatf("refresh_%0d", k), {31'd0, refresh}, 32'd1);
    check($sformatf("go_%0d", k), {28'd0, go}, {28'd0, exp_go});
    check($sformatf("fcnt_%0d", k), {28'd0, frame_count},
          32'(k % 16));
  endtask

  logic [3:0] tbl [14:26];

  initial begin
    checks  = 0;
    passes  = 0;
    reset   = 1'b1;
    enable  = 1'b1;
    restart = 4'b0000;
    // periods {ch3,ch2,ch1,ch0} = {0,5,3,1}
    period  = {4'd0, 4'd5, 4'd3, 4'd1};

    // restart[1] at #13 resyncs ch1 to 14,17,20,...
    // ch2 switches to period 2 after #17: fires 16,21,23,25
    tbl[14] = 4'b1011; tbl[15] = 4'b1001; tbl[16] = 4'b1101;
    tbl[17] = 4'b1011; tbl[18] = 4'b1001; tbl[19] = 4'b1001;
    tbl[20] = 4'b1011; tbl[21] = 4'b1101; tbl[22] = 4'b1001;
    tbl[23] = 4'b1111; tbl[24] = 4'b1001; tbl[25] = 4'b1101;
    tbl[26] = 4'b1011;

    step(3);
    check("rst_refresh", {31'd0, refresh}, 32'd0);
    check("rst_go", {28'd0, go}, 32'd0);
    check("rst_fcnt", {28'd0, frame_count}, 32'd0);

    // release on a falling edge; edge 10 carries refresh #1
    #4;
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      frame(k, {1'b1, ((k - 1) % 5 == 0),
                ((k - 1) % 3 == 0), 1'b1}, 4'b0000);
    end

    // div_cnt is 4 five edges after a refresh
    step(5);
    enable = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step(1);
      check($sformatf("pause_ref_%0d", c), {31'd0, refresh}, 32'd0);
      check($sformatf("pause_go_%0d", c), {28'd0, go}, 32'd0);
    end
    enable = 1'b1;
    // four decrements 4->0, refresh on the following edge
    step(4);
    check("resume_quiet", {31'd0, refresh}, 32'd0);
    step(1);
    check("resume_refresh", {31'd0, refresh}, 32'd1);
    check("resume_go", {28'd0, go}, 32'd9);
    check("resume_fcnt", {28'd0, frame_count}, 32'd12);

    // #13 would fire ch1; restart on the tick cycle blocks it
    frame(13, 4'b1001, 4'b0010);

    for (int k = 14; k <= 26; k++) begin
      frame(k, tbl[k], 4'b0000);
      if (k == 17)
        period[11:8] = 4'd2;
    end

    // async reset while refresh/go are high, off the clock edge
    #2;
    reset = 1'b1;
    #1;
    check("arst_refresh", {31'd0, refresh}, 32'd0);
    check("arst_go", {28'd0, go}, 32'd0);
    check("arst_fcnt", {28'd0, frame_count}, 32'd0);
    step(2);
    #3;
    reset = 1'b0;
    frame(1, 4'b1111, 4'b0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
